ahfp_ci_seq: RTL and testbench

Multicycle custom-instruction front end that sits directly upstream of the add/sub pipeline.
- Accepts an instruction (opcode n, dataa, datab) on a start/done handshake.
- Registers and presents operands to the add/sub unit; applies sign inversion for subtract.
- Counts the unit's fixed pipeline latency, captures the unit's result, and raises done.
- Also keeps a running-sum accumulator that reuses the same add path.

---
 rtl/ahfp_pkg.sv | 21 ++
 rtl/ahfp_lat_counter.sv | 30 +++
 rtl/ahfp_ci_seq.sv | 113 +++++++++++
 tb/tb_ahfp_ci_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahfp_pkg.sv
// Shared opcodes, state encoding and float constants for the add/sub custom-instruction front end.
package ahfp_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_ACC = 2'd2;
  localparam logic [1:0] OP_CLR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int          FP_SIGN_BIT = 31;
  localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
  localparam logic [31:0] FP_ONE      = 32'h3F80_0000;
  localparam logic [31:0] FP_TWO      = 32'h4000_0000;
  localparam logic [31:0] FP_THREE    = 32'h4040_0000;

endpackage

// File: rtl/ahfp_lat_counter.sv
// Loadable down-counter timing the add/sub pipeline latency.
// expired rises once the count has run down past 1, i.e. the cycle after the last tick.
module ahfp_lat_counter #(
  parameter int LATENCY = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LATENCY + 1);

  logic [CW-1:0] count;

  // Counting stops at zero so a stale WAIT can never wrap around.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(LATENCY);
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/ahfp_ci_seq.sv
// Multicycle custom-instruction sequencer feeding the add/sub pipeline, with a running-sum
// accumulator that reuses the same add path.
module ahfp_ci_seq
  import ahfp_pkg::*;
#(
  parameter int LATENCY = 7,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [1:0]       n,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] fp_a,
  output logic [WIDTH-1:0] fp_b,
  input  logic [WIDTH-1:0] fp_res
);

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic             accept;
  logic             cnt_load;
  logic             cnt_expired;

  assign accept   = (state == ST_IDLE) && start && clk_en;
  assign cnt_load = accept && (n != OP_CLR);

  ahfp_lat_counter #(
    .LATENCY (LATENCY)
  ) u_lat_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .en      (state == ST_WAIT),
    .expired (cnt_expired)
  );

  // The WAIT state ignores clk_en on purpose: the downstream pipeline free-runs, so the
  // result must be captured on the exact cycle it emerges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      op_q   <= OP_ADD;
      result <= '0;
      fp_a   <= '0;
      fp_b   <= '0;
      acc    <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q <= n;
            busy <= 1'b1;
            case (n)
              OP_ADD: begin
                fp_a  <= dataa;
                fp_b  <= datab;
                state <= ST_WAIT;
              end
              OP_SUB: begin
                fp_a  <= dataa;
                fp_b  <= {~datab[WIDTH-1], datab[WIDTH-2:0]};
                state <= ST_WAIT;
              end
              OP_ACC: begin
                fp_a  <= acc;
                fp_b  <= dataa;
                state <= ST_WAIT;
              end
              OP_CLR: begin
                result <= acc;
                acc    <= '0;
                done   <= 1'b1;
                state  <= ST_DONE;
              end
            endcase
          end
        end
        ST_WAIT: begin
          if (cnt_expired) begin
            result <= fp_res;
            if (op_q == OP_ACC) begin
              acc <= fp_res;
            end
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (clk_en) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahfp_ci_seq.sv
// Directed bench for ahfp_ci_seq with a behavioural add pipeline per latency variant
// and an expected-result queue popped at each done.
module tb_ahfp_ci_seq;
  import ahfp_pkg::*;

  localparam int L_MAIN = 7;
  localparam int L_SHORT = 1;
  localparam int L_LONG = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  n = 2'd0;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;

  logic [31:0] result7, fpa7, fpb7, fpres7;
  logic [31:0] result1, fpa1, fpb1, fpres1;
  logic [31:0] result12, fpa12, fpb12, fpres12;
  logic        done7, busy7, done1, busy1, done12, busy12;

  logic [31:0] pipe7 [L_MAIN];
  logic [31:0] pipe1 [L_SHORT];
  logic [31:0] pipe12 [L_LONG];

  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ahfp_ci_seq #(.LATENCY(L_MAIN), .WIDTH(32)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n),
    .dataa(dataa), .datab(datab), .result(result7), .done(done7), .busy(busy7),
    .fp_a(fpa7), .fp_b(fpb7), .fp_res(fpres7)
  );

  ahfp_ci_seq #(.LATENCY(L_SHORT), .WIDTH(32)) dut_short (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n),
    .dataa(dataa), .datab(datab), .result(result1), .done(done1), .busy(busy1),
    .fp_a(fpa1), .fp_b(fpb1), .fp_res(fpres1)
  );

  ahfp_ci_seq #(.LATENCY(L_LONG), .WIDTH(32)) dut_long (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n),
    .dataa(dataa), .datab(datab), .result(result12), .done(done12), .busy(busy12),
    .fp_a(fpa12), .fp_b(fpb12), .fp_res(fpres12)
  );

  // Single-precision <-> real conversion, normals and zero only.
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e11;
    if (f[30:0] == 31'd0) return 0.0;
    e11 = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e11, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e11;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e11 = d[62:52] - 11'd896;
    return {d[63], e11[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  // Behavioural add/sub units: a LATENCY-deep register chain behind each operand pair.
  always @(posedge clk) begin
    pipe7[0] <= fadd(fpa7, fpb7);
    for (int i = 1; i < L_MAIN; i++) pipe7[i] <= pipe7[i-1];
    pipe1[0] <= fadd(fpa1, fpb1);
    pipe12[0] <= fadd(fpa12, fpb12);
    for (int i = 1; i < L_LONG; i++) pipe12[i] <= pipe12[i-1];
  end

  assign fpres7 = pipe7[L_MAIN-1];
  assign fpres1 = pipe1[L_SHORT-1];
  assign fpres12 = pipe12[L_LONG-1];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at #1 after an edge; drives start for that cycle and returns one cycle later.
  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    n = op;
    dataa = a;
    datab = b;
    step();
    start = 1'b0;
    dataa = '0;
    datab = '0;
  endtask

  task automatic wait_done(input string tag, input int c0, input int exp_c);
    int c;
    logic [31:0] e;
    c = c0;
    while (done7 !== 1'b1 && c < 40) begin
      step();
      c++;
    end
    check_output({tag, " latency"}, 32'(c), 32'(exp_c));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check_output({tag, " result"}, result7, e);
  endtask

  initial begin
    int cnt;
    int l1, l7, l12;
    logic [31:0] r1, r7, r12;

    step();
    step();
    reset = 1'b0;
    #1;
    check_output("reset result", result7, FP_ZERO);
    check_output("reset done", {31'd0, done7}, 32'd0);
    check_output("reset busy", {31'd0, busy7}, 32'd0);
    check_output("reset fp_a", fpa7, FP_ZERO);
    check_output("reset fp_b", fpb7, FP_ZERO);
    step();

    $display("[TB] add");
    exp_q.push_back(FP_THREE);
    apply_stimulus(OP_ADD, FP_ONE, FP_TWO);
    check_output("add fp_a", fpa7, FP_ONE);
    check_output("add fp_b", fpb7, FP_TWO);
    check_output("add busy T+1", {31'd0, busy7}, 32'd1);
    check_output("add done T+1", {31'd0, done7}, 32'd0);
    wait_done("add", 1, 9);
    check_output("add busy T+9", {31'd0, busy7}, 32'd1);
    step();
    check_output("add idle busy", {31'd0, busy7}, 32'd0);
    check_output("add idle done", {31'd0, done7}, 32'd0);

    $display("[TB] sub");
    exp_q.push_back(FP_TWO);
    apply_stimulus(OP_SUB, FP_THREE, FP_ONE);
    check_output("sub fp_b", fpb7, 32'hBF80_0000);
    wait_done("sub", 1, 9);
    step();
    exp_q.push_back(32'h4080_0000);
    apply_stimulus(OP_SUB, FP_THREE, 32'hBF80_0000);
    check_output("sub neg fp_b", fpb7, FP_ONE);
    wait_done("sub neg", 1, 9);
    step();

    $display("[TB] accumulate");
    exp_q.push_back(FP_ZERO);
    apply_stimulus(OP_CLR, '0, '0);
    wait_done("clr0", 1, 1);
    step();
    exp_q.push_back(FP_ONE);
    apply_stimulus(OP_ACC, FP_ONE, 32'h1234_5678);
    check_output("acc fp_a", fpa7, FP_ZERO);
    wait_done("acc1", 1, 9);
    step();
    exp_q.push_back(32'h3FC0_0000);
    apply_stimulus(OP_ACC, 32'h3F00_0000, '0);
    wait_done("acc2", 1, 9);
    step();
    exp_q.push_back(32'h4020_0000);
    apply_stimulus(OP_ACC, FP_ONE, '0);
    wait_done("acc3", 1, 9);
    step();
    exp_q.push_back(32'h4020_0000);
    apply_stimulus(OP_CLR, '0, '0);
    wait_done("clr1", 1, 1);
    step();
    exp_q.push_back(FP_ONE);
    apply_stimulus(OP_ACC, FP_ONE, '0);
    wait_done("acc after clr", 1, 9);
    step();

    $display("[TB] handshake");
    exp_q.push_back(FP_THREE);
    apply_stimulus(OP_ADD, FP_ONE, FP_TWO);
    step();
    step();
    apply_stimulus(OP_ADD, FP_THREE, FP_THREE);
    check_output("intrude fp_a held", fpa7, FP_ONE);
    wait_done("intrude", 4, 9);
    step();
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done7 === 1'b1) cnt++;
      step();
    end
    check_output("intrude not queued", 32'(cnt), 32'd0);

    exp_q.push_back(FP_THREE);
    apply_stimulus(OP_ADD, FP_TWO, FP_ONE);
    repeat (7) step();
    clk_en = 1'b0;
    wait_done("stall", 8, 9);
    repeat (3) step();
    check_output("stall done held", {31'd0, done7}, 32'd1);
    check_output("stall result held", result7, FP_THREE);
    clk_en = 1'b1;
    step();
    check_output("stall release done", {31'd0, done7}, 32'd0);
    check_output("stall release busy", {31'd0, busy7}, 32'd0);

    clk_en = 1'b0;
    apply_stimulus(OP_ADD, FP_ONE, FP_ONE);
    check_output("no clk_en busy", {31'd0, busy7}, 32'd0);
    clk_en = 1'b1;
    step();

    $display("[TB] reset mid-op");
    apply_stimulus(OP_ADD, FP_ONE, FP_TWO);
    repeat (3) step();
    reset = 1'b1;
    #1;
    check_output("abort result", result7, FP_ZERO);
    check_output("abort busy", {31'd0, busy7}, 32'd0);
    check_output("abort fp_a", fpa7, FP_ZERO);
    check_output("abort fp_b", fpb7, FP_ZERO);
    @(negedge clk);
    reset = 1'b0;
    step();
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done7 === 1'b1 || busy7 === 1'b1) cnt++;
      step();
    end
    check_output("abort no done", 32'(cnt), 32'd0);
    exp_q.push_back(FP_TWO);
    apply_stimulus(OP_ADD, FP_ONE, FP_ONE);
    wait_done("post reset", 1, 9);
    step();

    $display("[TB] latency sweep");
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    l1 = -1; l7 = -1; l12 = -1;
    r1 = '0; r7 = '0; r12 = '0;
    apply_stimulus(OP_ADD, FP_ONE, FP_TWO);
    for (int c = 1; c <= 20; c++) begin
      if (done1 === 1'b1 && l1 < 0) begin l1 = c; r1 = result1; end
      if (done7 === 1'b1 && l7 < 0) begin l7 = c; r7 = result7; end
      if (done12 === 1'b1 && l12 < 0) begin l12 = c; r12 = result12; end
      step();
    end
    check_output("sweep L1 latency", 32'(l1), 32'(L_SHORT + 2));
    check_output("sweep L1 result", r1, FP_THREE);
    check_output("sweep L7 latency", 32'(l7), 32'(L_MAIN + 2));
    check_output("sweep L7 result", r7, FP_THREE);
    check_output("sweep L12 latency", 32'(l12), 32'(L_LONG + 2));
    check_output("sweep L12 result", r12, FP_THREE);
    check_output("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
